// File: rtl/hps_regfile_pkg.sv
// Shared constants for the HPS-to-DSP register file: word addresses, CTRL/STATUS
// bit positions and the default ID value.
package hps_regfile_pkg;
   localparam int unsigned ADDR_ID        = 32'h00;
   localparam int unsigned ADDR_CTRL      = 32'h01;
   localparam int unsigned ADDR_STATUS    = 32'h02;
   localparam int unsigned ADDR_FRAME_CNT = 32'h03;
   localparam int unsigned ADDR_PARAM0    = 32'h04;

   localparam int CTRL_ENABLE     = 0;
   localparam int CTRL_SOFT_RESET = 1;
   localparam int CTRL_APPLY_NOW  = 2;

   localparam int STAT_OVERFLOW = 0;
   localparam int STAT_PENDING  = 1;

   localparam logic [31:0] ID_DEFAULT = 32'h4844_5201;
endpackage

// File: rtl/hps_regfile_dsp_if.sv
// Avalon-MM bus as seen in the clk_dsp domain: the bridge drives it as master,
// the register file responds as slave.
interface hps_regfile_dsp_if #(
   parameter int WIDTH_ADDR = 8,
   parameter int WIDTH_DATA = 32,
   parameter int WIDTH_BE   = 8
);
   logic                  avl_write_dsp;
   logic                  avl_chipselect_dsp;
   logic [WIDTH_ADDR-1:0] avl_address_dsp;
   logic [WIDTH_BE-1:0]   avl_byteenable_dsp;
   logic [WIDTH_DATA-1:0] avl_writedata_dsp;
   logic [WIDTH_DATA-1:0] avl_readdata_dsp;

   modport master (
      output avl_write_dsp, avl_chipselect_dsp, avl_address_dsp,
             avl_byteenable_dsp, avl_writedata_dsp,
      input  avl_readdata_dsp
   );
   modport slave (
      input  avl_write_dsp, avl_chipselect_dsp, avl_address_dsp,
             avl_byteenable_dsp, avl_writedata_dsp,
      output avl_readdata_dsp
   );
endinterface

// File: rtl/hps_regfile_edge_det.sv
// Rising-edge detector. History resets to 1 so a level already high when reset
// releases is not reported as an edge.
module hps_regfile_edge_det (
   input  logic clk_dsp,
   input  logic reset_n,
   input  logic sig,
   output logic rise
);
   logic hist;

   always_ff @(posedge clk_dsp or negedge reset_n)
      if (!reset_n) hist <= 1'b1;
      else          hist <= sig;

   assign rise = sig & ~hist;
endmodule

// File: rtl/hps_regfile_dsp.sv
// HPS-to-DSP register file with frame-boundary double-buffered parameters.
// Build option: define HPS_REGFILE_FRAME_CNT_EN to implement the FRAME_CNT counter.
module hps_regfile_dsp
   import hps_regfile_pkg::*;
#(
   parameter int                    WIDTH_ADDR = 8,
   parameter int                    WIDTH_DATA = 32,
   parameter int                    WIDTH_BE   = 8,
   parameter int                    NUM_PARAM  = 4,
   parameter logic [WIDTH_DATA-1:0] ID_VALUE   = ID_DEFAULT
) (
   input  logic                                 clk_dsp,
   input  logic                                 reset_n,
   hps_regfile_dsp_if.slave                     avl,
   input  logic                                 vsync_in,
   input  logic                                 overflow_in,
   output logic                                 ctrl_enable,
   output logic                                 soft_reset_pulse,
   output logic [NUM_PARAM-1:0][WIDTH_DATA-1:0] param_active
);
   localparam int NB = WIDTH_DATA / 8;

   logic [31:0]                          addr_w;
   logic                                 wr_en, rd_en, ctrl_wr, stat_wr;
   logic                                 apply_now, vsync_rise, update;
   logic [NUM_PARAM-1:0]                 param_sel;
   logic                                 param_wr;
   logic                                 ovf_sticky, shadow_pending;
   logic [NUM_PARAM-1:0][WIDTH_DATA-1:0] shadow;
   logic [WIDTH_DATA-1:0]                rd_mux;
   logic                                 unused_be;

   assign addr_w  = 32'(avl.avl_address_dsp);
   assign wr_en   = avl.avl_chipselect_dsp &  avl.avl_write_dsp;
   assign rd_en   = avl.avl_chipselect_dsp & ~avl.avl_write_dsp;
   // Control/status bits all live in byte lane 0, so that lane gates their effects.
   assign ctrl_wr = wr_en && addr_w == ADDR_CTRL   && avl.avl_byteenable_dsp[0];
   assign stat_wr = wr_en && addr_w == ADDR_STATUS && avl.avl_byteenable_dsp[0];
   assign apply_now = ctrl_wr & avl.avl_writedata_dsp[CTRL_APPLY_NOW];
   assign update    = vsync_rise | apply_now;
   assign unused_be = ^avl.avl_byteenable_dsp;

   hps_regfile_edge_det u_vsync_edge (
      .clk_dsp (clk_dsp),
      .reset_n (reset_n),
      .sig     (vsync_in),
      .rise    (vsync_rise)
   );

   for (genvar i = 0; i < NUM_PARAM; i++) begin : g_param_sel
      assign param_sel[i] = wr_en && (addr_w == ADDR_PARAM0 + i);
   end
   assign param_wr = |param_sel;

   always_ff @(posedge clk_dsp or negedge reset_n)
      if (!reset_n) shadow <= '0;
      else
         for (int i = 0; i < NUM_PARAM; i++)
            for (int b = 0; b < NB; b++)
               if (param_sel[i] && avl.avl_byteenable_dsp[b])
                  shadow[i][b*8 +: 8] <= avl.avl_writedata_dsp[b*8 +: 8];

   // Copy takes the pre-write shadow; a coincident PARAM write keeps pending set.
   always_ff @(posedge clk_dsp or negedge reset_n)
      if (!reset_n) begin
         ctrl_enable      <= 1'b0;
         soft_reset_pulse <= 1'b0;
         ovf_sticky       <= 1'b0;
         shadow_pending   <= 1'b0;
         param_active     <= '0;
      end else begin
         soft_reset_pulse <= ctrl_wr & avl.avl_writedata_dsp[CTRL_SOFT_RESET];
         if (ctrl_wr) ctrl_enable <= avl.avl_writedata_dsp[CTRL_ENABLE];
         if (overflow_in)                                       ovf_sticky <= 1'b1;
         else if (stat_wr && avl.avl_writedata_dsp[STAT_OVERFLOW]) ovf_sticky <= 1'b0;
         if (update) begin
            param_active   <= shadow;
            shadow_pending <= param_wr;
         end else if (param_wr) begin
            shadow_pending <= 1'b1;
         end
      end

`ifdef HPS_REGFILE_FRAME_CNT_EN
   logic [31:0] frame_cnt;

   always_ff @(posedge clk_dsp or negedge reset_n)
      if (!reset_n)        frame_cnt <= '0;
      else if (vsync_rise) frame_cnt <= frame_cnt + 32'd1;
`endif

   always_comb begin
      rd_mux = '0;
      case (addr_w)
         ADDR_ID:     rd_mux = ID_VALUE;
         ADDR_CTRL:   rd_mux[CTRL_ENABLE] = ctrl_enable;
         ADDR_STATUS: begin
            rd_mux[STAT_OVERFLOW] = ovf_sticky;
            rd_mux[STAT_PENDING]  = shadow_pending;
         end
`ifdef HPS_REGFILE_FRAME_CNT_EN
         ADDR_FRAME_CNT: rd_mux = WIDTH_DATA'(frame_cnt);
`endif
         default:
            for (int i = 0; i < NUM_PARAM; i++)
               if (addr_w == ADDR_PARAM0 + i) rd_mux = shadow[i];
      endcase
   end

   always_ff @(posedge clk_dsp or negedge reset_n)
      if (!reset_n)   avl.avl_readdata_dsp <= '0;
      else if (rd_en) avl.avl_readdata_dsp <= rd_mux;
endmodule

// File: tb/tb_hps_regfile_dsp.sv
// Scoreboard bench for hps_regfile_dsp: expected read data is queued when a read
// is issued and checked when the registered read data appears.
module tb_hps_regfile_dsp;
   logic              clk_dsp = 1'b0;
   logic              reset_n;
   logic              vsync_in, overflow_in;
   logic              ctrl_enable, soft_reset_pulse;
   logic [3:0][31:0]  param_active;
   logic [31:0]       exp_q[$];
   int                n_vec = 0;
   int                n_err = 0;
   int                fc = 0;

   hps_regfile_dsp_if #(.WIDTH_ADDR(8), .WIDTH_DATA(32), .WIDTH_BE(8)) avl ();

   hps_regfile_dsp #(.WIDTH_ADDR(8), .WIDTH_DATA(32), .WIDTH_BE(8), .NUM_PARAM(4)) dut (
      .clk_dsp          (clk_dsp),
      .reset_n          (reset_n),
      .avl              (avl),
      .vsync_in         (vsync_in),
      .overflow_in      (overflow_in),
      .ctrl_enable      (ctrl_enable),
      .soft_reset_pulse (soft_reset_pulse),
      .param_active     (param_active)
   );

   always #5 clk_dsp = ~clk_dsp;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h, want %08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_dsp);
      #1;
   endtask

   task automatic bus_idle();
      avl.avl_write_dsp      = 1'b0;
      avl.avl_chipselect_dsp = 1'b0;
      avl.avl_address_dsp    = '0;
      avl.avl_byteenable_dsp = '0;
      avl.avl_writedata_dsp  = '0;
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [7:0] be);
      avl.avl_write_dsp      = 1'b1;
      avl.avl_chipselect_dsp = 1'b1;
      avl.avl_address_dsp    = a;
      avl.avl_byteenable_dsp = be;
      avl.avl_writedata_dsp  = d;
      tick();
      bus_idle();
   endtask

   task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
      avl.avl_write_dsp      = 1'b0;
      avl.avl_chipselect_dsp = 1'b1;
      avl.avl_address_dsp    = a;
      exp_q.push_back(exp);
      tick();
      bus_idle();
      if (exp_q.size() == 0) chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      else                   chk(tag, avl.avl_readdata_dsp, exp_q.pop_front());
   endtask

   task automatic vsync_pulse();
      vsync_in = 1'b1;
      tick();
      vsync_in = 1'b0;
      tick();
      fc++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "timeout");
   end

   initial begin
      bus_idle();
      reset_n     = 1'b0;
      vsync_in    = 1'b1;
      overflow_in = 1'b0;
      repeat (3) tick();
      chk("rst_en",    32'(ctrl_enable), 32'd0);
      chk("rst_srp",   32'(soft_reset_pulse), 32'd0);
      chk("rst_rdata", avl.avl_readdata_dsp, 32'd0);
      chk("rst_pa0",   param_active[0], 32'd0);
      reset_n = 1'b1;
      // vsync already high at release must not count as an edge
      repeat (2) tick();
      rd("fc_held_hi", 8'h03, 32'd0);
      vsync_in = 1'b0;
      tick();

      rd("id",       8'h00, 32'h4844_5201);
      rd("unmapped", 8'h7F, 32'd0);
      rd("rdata_hold_pre", 8'h00, 32'h4844_5201);
      tick();
      chk("rdata_hold", avl.avl_readdata_dsp, 32'h4844_5201);

      wr(8'h04, 32'h1122_3344, 8'h03);
      rd("p0_be03",  8'h04, 32'h0000_3344);
      wr(8'h04, 32'hAABB_CCDD, 8'hFF);
      rd("p0_full",  8'h04, 32'hAABB_CCDD);
      rd("pend_set", 8'h02, 32'h2);
      chk("pa0_hold", param_active[0], 32'd0);
      vsync_pulse();
      chk("pa0_vsync", param_active[0], 32'hAABB_CCDD);
      rd("pend_clr", 8'h02, 32'h0);

      // PARAM1 write coincident with a vsync edge
      vsync_in = 1'b1;
      wr(8'h05, 32'h5555_6666, 8'hFF);
      vsync_in = 1'b0;
      fc++;
      chk("pa1_old", param_active[1], 32'd0);
      rd("pend_coinc", 8'h02, 32'h2);
      wr(8'h01, 32'h4, 8'h01);
      chk("pa1_apply", param_active[1], 32'h5555_6666);
      chk("pa0_apply", param_active[0], 32'hAABB_CCDD);
      rd("pend_apply", 8'h02, 32'h0);
      rd("ctrl_apply", 8'h01, 32'h0);

      overflow_in = 1'b1;
      tick();
      overflow_in = 1'b0;
      rd("ovf_set", 8'h02, 32'h1);
      wr(8'h02, 32'h1, 8'h01);
      rd("ovf_w1c", 8'h02, 32'h0);
      overflow_in = 1'b1;
      wr(8'h02, 32'h1, 8'h01);
      overflow_in = 1'b0;
      rd("ovf_setwins", 8'h02, 32'h1);
      wr(8'h02, 32'h1, 8'h01);
      rd("ovf_clr2", 8'h02, 32'h0);

      avl.avl_write_dsp      = 1'b1;
      avl.avl_chipselect_dsp = 1'b1;
      avl.avl_address_dsp    = 8'h01;
      avl.avl_byteenable_dsp = 8'hFF;
      avl.avl_writedata_dsp  = 32'h3;
      chk("srp_before", 32'(soft_reset_pulse), 32'd0);
      tick();
      bus_idle();
      chk("srp_high", 32'(soft_reset_pulse), 32'd1);
      chk("en_set",   32'(ctrl_enable), 32'd1);
      tick();
      chk("srp_low",  32'(soft_reset_pulse), 32'd0);
      rd("ctrl_rd", 8'h01, 32'h1);
      wr(8'h01, 32'h0, 8'h00);
      rd("ctrl_be0", 8'h01, 32'h1);
      wr(8'h01, 32'h0, 8'hFF);
      chk("en_clr", 32'(ctrl_enable), 32'd0);

      wr(8'h08, 32'hDEAD_BEEF, 8'hFF);
      rd("unmapped_wr", 8'h08, 32'd0);
      rd("p3_untouched", 8'h07, 32'd0);

`ifdef HPS_REGFILE_FRAME_CNT_EN
      rd("fc_two", 8'h03, 32'(fc));
      repeat (3) vsync_pulse();
      rd("fc_five", 8'h03, 32'(fc));
      force dut.frame_cnt = 32'hFFFF_FFFF;
      tick();
      release dut.frame_cnt;
      tick();
      rd("fc_max", 8'h03, 32'hFFFF_FFFF);
      vsync_pulse();
      rd("fc_wrap", 8'h03, 32'd0);
`else
      repeat (3) vsync_pulse();
      rd("fc_absent", 8'h03, 32'd0);
`endif

      // asynchronous reset mid-cycle clears state without a clock edge
      #3;
      reset_n = 1'b0;
      #1;
      chk("arst_pa0", param_active[0], 32'd0);
      chk("arst_pa1", param_active[1], 32'd0);
      tick();
      reset_n = 1'b1;
      tick();
      rd("arst_p0", 8'h04, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
